mod_down_counter: RTL and testbench
===================================

Name: mod_down_counter

Overview:
Loadable modulo-MOD down-counter and timer. It is the count-down companion to the team's loadable modulo up-counter. It counts from a loaded value toward 0. In free-run mode it wraps to MOD-1; in one-shot mode it stops at 0 and flags expiry. It serves as a programmable interval timer and as the borrow stage of down-counting chains.

Parameters:
WIDTH, 4, width of count value and load bus
MOD, 11, modulus; legal count range 0..MOD-1; legal values 2 <= MOD <= 2**WIDTH

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  reset, synchronous, active-high
lde  input  1  load enable; loads ld and arms the counter
ld  input  WIDTH  load value
en  input  1  count enable; one decrement step per cycle when high
oneshot  input  1  mode select: 0 = free-run wrap, 1 = stop at 0
Q  output  WIDTH  current count (registered)
tc  output  1  terminal-count pulse (registered, one cycle)
busy  output  1  high while in RUN
done  output  1  high while in DONE (one-shot expired)

Behaviour:
- Reset (rst=1 at clk edge): Q=0, tc=0, state=IDLE, busy=0, done=0. rst overrides all other inputs, including mid-count.
- Priority each edge: rst > lde > count step.
- FSM states: IDLE, RUN, DONE. busy=(state==RUN), done=(state==DONE); both are decoded from the registered state.
- Load, any state:
  - lde=1 -> Q <= clamp(ld), state <= RUN, tc <= 0.
  - clamp(ld) = ld if ld <= MOD-1, else MOD-1.
  - Load of 0 is legal; the next enabled step is a terminal step.
- IDLE: Q holds 0. en is ignored; counting starts only via lde.
- RUN, en=0: Q holds, tc <= 0.
- RUN, en=1, Q != 0: Q <= Q-1, tc <= 0.
- RUN, en=1, Q == 0 (terminal step), with tc <= 1 in both cases:
  - oneshot=0 -> Q <= MOD-1, state stays RUN.
  - oneshot=1 -> Q stays 0, state <= DONE.
- DONE: Q holds 0 and tc <= 0. en is ignored. Only lde (-> RUN) or rst (-> IDLE) leave DONE.
- oneshot is sampled only at terminal steps. Changing it mid-count has no other effect.
- tc timing:
  - Asserted for exactly one cycle, in the cycle after the terminal-step edge.
  - Free-run: coincides with Q==MOD-1. One-shot: coincides with done rising.
  - Back-to-back wraps (MOD consecutive enabled cycles) give tc once every MOD cycles.
- lde coincident with a terminal step: load wins, tc <= 0, no wrap or expiry.
- Arithmetic:
  - Q is WIDTH bits unsigned and never leaves 0..MOD-1.
  - No underflow through 2**WIDTH-1; the wrap target is MOD-1 even when MOD < 2**WIDTH.
- Simulation-time check: flag an error if MOD < 2 or MOD > 2**WIDTH.

Test Plan:
- Reset: rst=1 for 2 cycles with lde=1, ld=7 -> Q=0, tc=0, busy=0, done=0. After release with en=1, lde=0 -> Q stays 0 and state stays IDLE.
- Free-run wrap: lde with ld=3, oneshot=0, then en=1 -> Q sequence 3,2,1,0,10,9. tc=1 only in the cycle Q=10. busy=1 throughout.
- One-shot expiry: lde with ld=2, oneshot=1, en=1 -> Q sequence 2,1,0 then holds 0. tc one pulse coincident with done rising, busy=0. Further en has no effect; a new lde with ld=4 returns to RUN with Q=4.
- Load clamp and priority:
  - lde with ld=15 -> Q=10.
  - lde with ld=6 asserted while Q=0, en=1 -> Q=6 and tc=0.
- Enable gating: RUN at Q=5, en=0 for 3 cycles -> Q stays 5 and tc=0. en=1 resumes with 4.
- Reset mid-operation: RUN at Q=5 with en=1, assert rst -> next cycle Q=0, IDLE, tc=0. Repeat with rst in DONE -> done=0 next cycle.

Source files
------------

// File: rtl/mod_down_counter.sv
// Loadable modulo-MOD down-counter / interval timer with free-run wrap and
// one-shot expiry; the terminal step also serves as the borrow of a counter chain.
module mod_down_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lde,
    input  logic [WIDTH-1:0] ld,
    input  logic             en,
    input  logic             oneshot,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // A modulus outside 2..2**WIDTH cannot be represented by the count register.
    generate
        if (MOD < 2 || MOD > (2 ** WIDTH)) begin : g_bad_mod
            $error("mod_down_counter: MOD=%0d is outside 2..2**WIDTH (WIDTH=%0d)", MOD, WIDTH);
        end
    endgenerate

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q,   cnt_d;
    logic             tc_q,    tc_d;
    logic [WIDTH-1:0] ld_clamp_s;

    // Out-of-range load values saturate to the top of the count range.
    always_comb begin
        if (ld > MAX_CNT) begin
            ld_clamp_s = MAX_CNT;
        end else begin
            ld_clamp_s = ld;
        end
    end

    // Next-state logic: load beats the count step; rst is handled in the register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tc_d    = 1'b0;
        if (lde) begin
            state_d = ST_RUN;
            cnt_d   = ld_clamp_s;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = ZERO;
                end
                ST_RUN: begin
                    if (en && (cnt_q == ZERO)) begin
                        // Terminal step: oneshot is only consulted here.
                        tc_d = 1'b1;
                        if (oneshot) begin
                            state_d = ST_DONE;
                            cnt_d   = ZERO;
                        end else begin
                            cnt_d   = MAX_CNT;
                        end
                    end else if (en) begin
                        cnt_d = cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_DONE: begin
                    cnt_d = ZERO;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = ZERO;
                end
            endcase
        end
    end

    // State, count and terminal-count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= ZERO;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
        end
    end

    assign Q    = cnt_q;
    assign tc   = tc_q;
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_mod_down_counter.sv
// Self-checking bench for mod_down_counter: directed scenarios followed by
// randomized traffic, all checked against a behavioural model.
module tb_mod_down_counter;

    localparam int WIDTH = 4;
    localparam int MOD   = 11;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             lde = 1'b0;
    logic [WIDTH-1:0] ld = '0;
    logic             en = 1'b0;
    logic             oneshot = 1'b0;
    logic [WIDTH-1:0] Q;
    logic             tc;
    logic             busy;
    logic             done;

    int tests_run = 0;
    int failures  = 0;

    // Behavioural model: mode 0 = idle, 1 = running, 2 = expired.
    int m_q = 0;
    int m_mode = 0;
    int m_tc = 0;

    mod_down_counter #(.WIDTH(WIDTH), .MOD(MOD)) dut (
        .clk(clk), .rst(rst), .lde(lde), .ld(ld), .en(en), .oneshot(oneshot),
        .Q(Q), .tc(tc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic l, input int v, input logic e, input logic o);
        if (r) begin
            m_q = 0; m_mode = 0; m_tc = 0;
        end else if (l) begin
            m_q = (v > MOD - 1) ? MOD - 1 : v;
            m_mode = 1; m_tc = 0;
        end else if (m_mode == 1 && e) begin
            if (m_q > 0) begin
                m_q = m_q - 1; m_tc = 0;
            end else begin
                m_tc = 1;
                if (o) m_mode = 2;
                else   m_q = MOD - 1;
            end
        end else begin
            m_tc = 0;
        end
    endtask

    // One clock edge with the given inputs; outputs compared to the model 1ns later.
    task automatic step(input logic r, input logic l, input int v, input logic e, input logic o);
        rst = r; lde = l; ld = WIDTH'(v); en = e; oneshot = o;
        @(posedge clk);
        model_edge(r, l, v, e, o);
        #1;
        check("Q", 32'(Q), 32'(m_q));
        check("tc", 32'(tc), 32'(m_tc));
        check("busy", 32'(busy), (m_mode == 1) ? 32'd1 : 32'd0);
        check("done", 32'(done), (m_mode == 2) ? 32'd1 : 32'd0);
    endtask

    task automatic expect_out(input string tag, input int q, input int t, input int b, input int d);
        check({tag, ".Q"}, 32'(Q), 32'(q));
        check({tag, ".tc"}, 32'(tc), 32'(t));
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".done"}, 32'(done), 32'(d));
    endtask

    initial begin
        int fr_q[5];
        int fr_tc[5];
        int tc_count;
        fr_q  = '{2, 1, 0, 10, 9};
        fr_tc = '{0, 0, 0, 1, 0};

        // Reset overrides a pending load.
        step(1, 1, 7, 0, 0);
        step(1, 1, 7, 0, 0);
        expect_out("reset", 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        expect_out("idle_en_ignored", 0, 0, 0, 0);

        // Free-run wrap from 3.
        step(0, 1, 3, 0, 0);
        expect_out("fr_load", 3, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, 0);
            expect_out($sformatf("fr_seq%0d", i), fr_q[i], fr_tc[i], 1, 0);
        end

        // One-shot expiry from 2.
        step(0, 1, 2, 0, 1);
        step(0, 0, 0, 1, 1);
        expect_out("os_1", 1, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        expect_out("os_0", 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        expect_out("os_expire", 0, 1, 0, 1);
        step(0, 0, 0, 1, 0);
        expect_out("os_hold", 0, 0, 0, 1);
        step(0, 1, 4, 1, 0);
        expect_out("os_reload", 4, 0, 1, 0);

        // Clamp and load-over-terminal-step priority.
        step(0, 1, 15, 0, 0);
        expect_out("clamp", 10, 0, 1, 0);
        step(0, 1, 0, 0, 1);
        step(0, 1, 6, 1, 1);
        expect_out("lde_beats_tc", 6, 0, 1, 0);

        // Enable gating.
        step(0, 1, 5, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        expect_out("en_gate", 5, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        expect_out("en_resume", 4, 0, 1, 0);

        // Reset mid-count and while expired.
        step(0, 1, 5, 1, 0);
        step(1, 0, 0, 1, 0);
        expect_out("rst_run", 0, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        expect_out("done_before_rst", 0, 1, 0, 1);
        step(1, 0, 0, 1, 1);
        expect_out("rst_done", 0, 0, 0, 0);

        // Back-to-back wraps: one tc per MOD enabled cycles.
        step(0, 1, MOD - 1, 0, 0);
        tc_count = 0;
        for (int i = 0; i < 3 * MOD; i++) begin
            step(0, 0, 0, 1, 0);
            if (tc === 1'b1) tc_count++;
        end
        check("tc_period", 32'(tc_count), 32'd3);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
